// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// The future receiver imports this package as well.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

   // 100 MHz / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   // Narrower words are zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [8:0] d, input bit mode);
      return (^d) ^ mode;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: drains one word per handshake into a start/data/parity/stop frame.
// Ready reopens in the last stop cycle so a held valid gives gap-free back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int UART_DLEN    = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_txb_tvalid,
   output logic                 o_txb_tready,
   input  logic [UART_DLEN-1:0] i_txb_tdata,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if (UART_DLEN < 5 || UART_DLEN > 9) begin : g_bad_dlen
      $error("uart_tx: UART_DLEN must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam bit PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   uart_tx_state_e       state;
   logic [UART_DLEN-1:0] shreg;
   logic                 par;
   logic [3:0]           bit_cnt;
   logic                 tick;
   logic                 last_stop;
   logic                 hs;

   // Counter idles at zero, so every frame starts on a fresh bit period.
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rstn (rstn),
      .clr  (state == IDLE),
      .en   (1'b1),
      .tick (tick)
   );

   assign last_stop    = (state == STOP) && tick && (bit_cnt == 4'(STOP_BITS - 1));
   assign o_txb_tready = (state == IDLE) || last_stop;
   assign hs           = i_txb_tvalid && o_txb_tready;
   assign o_done       = last_stop;
   assign o_busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         o_tx    <= 1'b1;
         shreg   <= '0;
         par     <= 1'b0;
         bit_cnt <= '0;
      end else if (hs) begin
         // hs is only possible in IDLE or the final stop cycle
         state   <= START;
         o_tx    <= 1'b0;
         shreg   <= i_txb_tdata;
         par     <= parity_of(9'(i_txb_tdata), PAR_MODE);
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: o_tx <= 1'b1;
            START:
               if (tick) begin
                  state   <= DATA;
                  o_tx    <= shreg[0];
                  bit_cnt <= '0;
               end
            DATA:
               if (tick) begin
                  if (bit_cnt == 4'(UART_DLEN - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        o_tx  <= par;
                     end else begin
                        state <= STOP;
                        o_tx  <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     shreg   <= shreg >> 1;
                     o_tx    <= shreg[1];
                  end
               end
            PARITY:
               if (tick) begin
                  state   <= STOP;
                  o_tx    <= 1'b1;
                  bit_cnt <= '0;
               end
            STOP:
               if (tick) begin
                  if (last_stop) begin
                     state <= IDLE;
                     o_tx  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            default: begin
               state <= IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx over four parity/stop configurations at 4 clocks per bit.
// Drivers queue each accepted word; monitors rebuild every frame cycle by cycle and compare.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int NCFG = 4;
   // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 8N2
   localparam logic [NCFG-1:0] PEN   = 4'b0110;
   localparam logic [NCFG-1:0] PODD  = 4'b0100;
   localparam logic [NCFG-1:0] STOP2 = 4'b1000;

   typedef struct {
      logic [7:0] d;
      int         start;
   } frm_t;

   logic clk;
   int   cyc;
   int   passes;
   int   total;
   logic [NCFG-1:0] fin;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s cfg%0d: got %h, expected %h (cycle %0d)", nm, g, act, exp, cyc);
   endtask

   // Reference frame: list of bit levels from the framing rules, each stretched to CPB cycles.
   // Bit k of the result is the line level in cycle k+1 after the handshake.
   function automatic logic [63:0] frame_wave(input logic [7:0] d, input int pe, input int po, input int sb);
      logic       lv[$];
      logic [63:0] v;
      int          k;
      v = '0;
      k = 0;
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(d[i]);
      if (pe != 0) lv.push_back((^d) ^ (po != 0));
      for (int s = 0; s < sb; s++) lv.push_back(1'b1);
      foreach (lv[i])
         for (int c = 0; c < CPB; c++) begin
            v[k] = lv[i];
            k++;
         end
      return v;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int PE = PEN[g] ? 1 : 0;
      localparam int PO = PODD[g] ? 1 : 0;
      localparam int SB = STOP2[g] ? 2 : 1;
      localparam int NB = (1 + 8 + PE + SB) * CPB;
      localparam logic [63:0] MASK = (64'(1) << NB) - 64'(1);
      localparam logic [63:0] LAST = 64'(1) << (NB - 1);

      logic       rstn, tvalid, tready, tx, busy, done;
      logic [7:0] tdata;
      frm_t       q[$];
      frm_t       f;
      int         k;
      logic       in_frame;
      logic [63:0] atx, adn, ard, abz;

      uart_tx #(
         .UART_DLEN   (8),
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (PE),
         .PARITY_ODD  (PO),
         .STOP_BITS   (SB)
      ) dut (
         .clk          (clk),
         .rstn         (rstn),
         .i_txb_tvalid (tvalid),
         .o_txb_tready (tready),
         .i_txb_tdata  (tdata),
         .o_tx         (tx),
         .o_busy       (busy),
         .o_done       (done)
      );

      // Called at a negedge; returns one negedge after the handshake with tvalid still high.
      task automatic send(input logic [7:0] w);
         int n;
         n = 0;
         tvalid = 1'b1;
         tdata  = w;
         while (!tready && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("hs_ready", g, 64'(tready), 64'd1);
         if (tready) q.push_back('{w, cyc + 1});
         @(negedge clk);
      endtask

      initial begin
         rstn = 1'b0;
         tvalid = 1'b0;
         tdata = 8'h00;
         repeat (3) @(negedge clk);
         chk("reset_state", g, 64'({tx, busy, done, tready}), 64'b1001);
         rstn = 1'b1;
         repeat (2) @(negedge clk);

         send(8'hA5);
         tvalid = 1'b0;
         repeat (NB + 4) @(negedge clk);

         send(8'h00);
         send(8'hFF);
         tvalid = 1'b0;
         repeat (NB + 4) @(negedge clk);

         send(8'h07);
         tvalid = 1'b0;
         repeat (NB + 2) @(negedge clk);
         send(8'h3C);
         tvalid = 1'b0;
         repeat (NB + 2) @(negedge clk);

         // data changes after the handshake must not reach the line
         send(8'h81);
         tvalid = 1'b0;
         tdata = 8'hFF;
         repeat (NB + 3) @(negedge clk);

         for (int i = 0; i < 8; i++) begin
            send(8'($urandom));
            if ($urandom_range(1) == 0) begin
               tvalid = 1'b0;
               tdata = 8'($urandom);
               repeat ($urandom_range(60, 1)) @(negedge clk);
            end
         end
         tvalid = 1'b0;
         repeat (NB + 4) @(negedge clk);

         // reset during cycle 15 of a frame (inside the data bits)
         send(8'($urandom));
         tvalid = 1'b0;
         repeat (14) @(posedge clk);
         #1 rstn = 1'b0;
         #1 chk("abort_state", g, 64'({tx, busy, done}), 64'b100);
         repeat (3) @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         chk("ready_after_rst", g, 64'(tready), 64'd1);
         send(8'h5A);
         tvalid = 1'b0;
         repeat (NB + 4) @(negedge clk);

         chk("queue_drained", g, 64'(q.size()), 64'd0);
         fin[g] = 1'b1;
      end

      initial begin
         in_frame = 1'b0;
         k = 0;
         forever begin
            @(negedge clk);
            if (!rstn) begin
               in_frame = 1'b0;
               q.delete();
            end else begin
               if (!in_frame && q.size() > 0 && q[0].start == cyc) begin
                  f = q.pop_front();
                  in_frame = 1'b1;
                  k = 0;
                  atx = '0; adn = '0; ard = '0; abz = '0;
               end
               if (in_frame) begin
                  atx[k] = tx;
                  adn[k] = done;
                  ard[k] = tready;
                  abz[k] = busy;
                  k++;
                  if (k == NB) begin
                     chk("frame_tx", g, atx, frame_wave(f.d, PE, PO, SB));
                     chk("frame_done", g, adn, LAST);
                     chk("frame_ready", g, ard, LAST);
                     chk("frame_busy", g, abz, MASK);
                     in_frame = 1'b0;
                  end
               end else begin
                  chk("idle_state", g, 64'({tx, busy, done, tready}), 64'b1001);
               end
            end
         end
      end
   end

   initial begin
      int n;
      fin = '0;
      n = 0;
      while (fin != '1 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (fin != '1) chk("all_finished", 0, 64'(fin), 64'hF);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains the transmit buffer stream: it accepts one `UART_DLEN`-bit word per handshake and shifts it out on `o_tx` as a standard asynchronous frame (start bit, data LSB first, optional parity, 1 or 2 stop bits). It is the reader side of the `txb` stream that `uart_controller` fills. It sits between the tx FIFO and the pad.

## Interface
Parameters:
- `UART_DLEN`, default 8: data bits per frame; legal range 5–9.
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); must be ≥ 2, otherwise elaboration error.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, default 1: 1 or 2; any other value is an elaboration error.

Ports:
- `clk`  in  1: single clock.
- `rstn`  in  1: reset, asynchronous and active-low.
- `i_txb_tvalid`  in  1: word available from the tx buffer.
- `o_txb_tready`  out  1: transmitter can accept a word.
- `i_txb_tdata`  in  `UART_DLEN`: word to send.
- `o_tx`  out  1: serial line; idles high.
- `o_busy`  out  1: a frame is in progress.
- `o_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- Reset values: state = IDLE, `o_tx` = 1, `o_busy` = 0, `o_done` = 0. `o_txb_tready` = 1 whenever state is IDLE, including after reset.
- Handshake occurs when `i_txb_tvalid & o_txb_tready`. On a handshake:
  - latch `i_txb_tdata` into the shift register;
  - compute parity as XOR of the data, inverted if `PARITY_ODD`;
  - go to START.
- Baud counter runs 0..`CLKS_PER_BIT`-1. State advances or the data shifts only on terminal count. The baud counter clears on every state entry.
- START drives `o_tx` = 0 for one bit time.
- DATA sends bit 0 first. A bit counter runs 0..`UART_DLEN`-1.
- After DATA, go to PARITY if `PARITY_EN`, else go to STOP.
- STOP drives `o_tx` = 1 for `STOP_BITS` bit times.
- `o_txb_tready` is also 1 in the final cycle of the last stop bit. A handshake in that cycle goes directly to START, giving back-to-back frames with no idle gap. With no handshake, go to IDLE.
- `o_done` pulses in that same final stop cycle.
- `o_busy` = 1 in every state other than IDLE.
- `o_tx` is driven from a flop: no combinational path from inputs to the pin.
- `i_txb_tdata` is ignored after the handshake. `i_txb_tvalid` deasserting mid-frame has no effect.
- Reset asserted mid-frame:
  - `o_tx` goes to 1 immediately (asynchronous);
  - the frame is aborted and no `o_done` is issued;
  - after release, the block is in IDLE.

## Timing
- Handshake is in cycle 0. `o_tx` falls in cycle 1 (1-cycle latency).
- Frame length N = (1 + `UART_DLEN` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, occupying cycles 1..N.
- `o_done` = 1 in cycle N. `o_txb_tready` = 0 in cycles 1..N-1 and = 1 in cycle N.
- Sustained throughput: one word per N cycles when `i_txb_tvalid` is held high.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. No jitter between frames.

## Structure
- `uart_pkg` holds:
  - `typedef enum logic [2:0] uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - parity-mode localparams;
  - the default `CLKS_PER_BIT`.
  The future `uart_rx` will share this package.
- Sub-module `uart_baud_gen`: a parameterized counter with inputs `clr`/`en` and a terminal-count output `tick`. It will be reused by `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `UART_DLEN` = 8 unless stated.
- **Single frame:** no parity, 1 stop, send 0xA5.
  - `o_tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, over cycles 1–40.
  - `o_done` = 1 only in cycle 40; `o_txb_tready` = 0 in cycles 1–39.
- **Back-to-back:** `i_txb_tvalid` held high with 0x00 then 0xFF.
  - Second handshake in cycle 40; second start bit in cycles 41–44.
  - Two `o_done` pulses, at cycles 40 and 80.
- **Parity:** `PARITY_EN` = 1, send 0x07.
  - Even parity: parity bit = 1 in cycles 37–40.
  - `PARITY_ODD` = 1: parity bit = 0.
  - Frame is 44 cycles in both cases.
- **Two stop bits:** `STOP_BITS` = 2, send 0x3C.
  - Stop level 1 held in cycles 37–44; `o_done` at cycle 44.
- **Reset mid-frame:** `rstn` low at cycle 15 (in DATA).
  - `o_tx` = 1 within the same cycle; no `o_done`.
  - After release, `o_txb_tready` = 1; a new 0x5A frame is correct.
- **Data stability:** change `i_txb_tdata` from 0x81 to 0xFF at cycle 2.
  - The transmitted bits still encode 0x81.
